bsg_mem_2r1w_rr_sched: RTL
==========================

Name: bsg_mem_2r1w_rr_sched

Overview:
- Shares one 2-read/1-write register-file macro between rd_clients_p read requesters and wr_clients_p write requesters.
- Each cycle it grants up to two reads and one write, using independent round-robin pointers.
- The register file has no read/write same-address support, so the block never drives a read and a write to the same address in the same cycle.
- Read data returns registered on two response lanes, tagged with client id, one cycle after the grant.

Parameters:
width_p, 32, data word width
els_p, 32, register-file depth
rd_clients_p, 4, number of read requesters (>=2)
wr_clients_p, 2, number of write requesters (>=1)
addr_width_lp, $clog2(els_p), address width (derived)
id_width_lp, $clog2(rd_clients_p), response client-id width (derived)

Ports:
clk_i  in  1  single clock, rising edge
reset_n_i  in  1  asynchronous, active-low reset
rd_v_i  in  rd_clients_p  read request valid, one bit per client
rd_addr_i  in  rd_clients_p*addr_width_lp  read addresses, client i at slice i
rd_yumi_o  out  rd_clients_p  read granted this cycle; client drops or changes its request next cycle
wr_v_i  in  wr_clients_p  write request valid
wr_addr_i  in  wr_clients_p*addr_width_lp  write addresses
wr_data_i  in  wr_clients_p*width_p  write data
wr_yumi_o  out  wr_clients_p  write granted (committed this cycle)
r0_v_o/r1_v_o  out  1 each  memory read port enables
r0_addr_o/r1_addr_o  out  addr_width_lp each  memory read addresses
r0_data_i/r1_data_i  in  width_p each  memory asynchronous read data
w_v_o  out  1  memory write enable
w_addr_o  out  addr_width_lp  memory write address
w_data_o  out  width_p  memory write data
resp0_v_o/resp1_v_o  out  1 each  response lane valid
resp0_id_o/resp1_id_o  out  id_width_lp each  client id of the response
resp0_data_o/resp1_data_o  out  width_p each  registered read data

Behaviour:
- Reset (reset_n_i low, asynchronous): rd_ptr_r=0, wr_ptr_r=0, resp*_v_o=0, resp*_id_o=0, resp*_data_o=0.
- While reset_n_i is low, all yumi outputs and all memory v outputs are forced to 0.
- Write grant:
  - The first wr_v_i set, scanning cyclically from wr_ptr_r, is granted.
  - That client's address and data drive w_*_o; w_v_o=1.
  - wr_yumi_o is one-hot.
  - wr_ptr_r becomes (granted+1) mod wr_clients_p; it is unchanged if no write is granted.
- Read eligibility: rd_v_i[i] && !(w_v_o && rd_addr[i]==w_addr_o). Writes win address conflicts; a conflicting read stays pending.
- Read grant:
  - Lane0 takes the first eligible client scanning cyclically from rd_ptr_r.
  - Lane1 takes the next eligible client after lane0's.
  - The chosen clients' addresses drive r0/r1; r*_v_o=1 only for lanes that are used.
  - rd_yumi_o has at most two bits set.
  - rd_ptr_r becomes (last granted+1) mod rd_clients_p; it is unchanged if nothing is granted.
  - Two clients reading the same address may both be granted in one cycle.
- Response: at the clock edge after a grant, resp_k_v_o=1, resp_k_id_o=client, resp_k_data_o=r_k_data_i as sampled. A response is held for exactly one cycle; there is no back-pressure and clients must accept it.
- A lane with no grant has resp_k_v_o=0 next cycle; id and data hold their previous values.
- Fewer than 2 eligible readers: lane1 stays unused. Lane0 is used first.
- Grants are combinational from the request inputs; the only state is the two pointers and the response registers.
- Reset asserted mid-operation: in-flight responses are dropped. Pending requests are not remembered, so clients re-present them.
- Sim-only assertions: the block never issues a read and write to the same address in one cycle; every address is < els_p.

Optional Feature:
BSG_MEM_2R1W_RR_SCHED_BYPASS_EN
- Defined:
  - Address-conflicting reads are eligible.
  - The memory read port for a conflicting lane is driven with r_k_v_o=0.
  - The response captures w_data_o instead of r_k_data_i, giving write-then-read ordering.
  - No read is deferred because of a write.
- Undefined: the conflict deferral described above applies.

Test Plan:
- Reset: hold reset_n_i=0 with all requests asserted -> all yumi=0, all resp_v=0. Release reset -> first cycle grants rd clients 0 and 1 and wr client 0.
- Read round-robin: all 4 readers request continuously -> grant pairs {0,1},{2,3},{0,1}. Responses arrive one cycle after each grant with the matching ids.
- Read-write conflict, macro off: write addr 5 with data 0xA5A5A5A5; reader 2 reads addr 5 in the same cycle -> reader 2 is deferred (yumi=0). The next cycle it is granted and its response is 0xA5A5A5A5.
- Read-write conflict, macro on: same stimulus -> reader 2 is granted in the same cycle and its response data is 0xA5A5A5A5.
- Single-reader fairness: only reader 3 requests -> lane0 is granted to client 3, resp1_v_o=0, rd_ptr_r becomes 0.
- Async reset mid-flight: assert reset_n_i between a grant and its response edge -> resp_v stays 0 and the pointers return to 0.

Source files
------------

// File: rtl/bsg_mem_2r1w_rr_sched.sv
// bsg_mem_2r1w_rr_sched: round-robin scheduler sharing one 2R1W register file among read and write clients.
// Define BSG_MEM_2R1W_RR_SCHED_BYPASS_EN to forward write data to same-address reads instead of deferring them.
module bsg_mem_2r1w_rr_sched #(
    parameter int width_p      = 32,
    parameter int els_p        = 32,
    parameter int rd_clients_p = 4,
    parameter int wr_clients_p = 2,
    localparam int addr_width_lp = $clog2(els_p),
    localparam int id_width_lp   = $clog2(rd_clients_p),
    localparam int wp_width_lp   = (wr_clients_p > 1) ? $clog2(wr_clients_p) : 1
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic [rd_clients_p-1:0]                rd_v_i,
    input  logic [rd_clients_p*addr_width_lp-1:0]  rd_addr_i,
    output logic [rd_clients_p-1:0]                rd_yumi_o,
    input  logic [wr_clients_p-1:0]                wr_v_i,
    input  logic [wr_clients_p*addr_width_lp-1:0]  wr_addr_i,
    input  logic [wr_clients_p*width_p-1:0]        wr_data_i,
    output logic [wr_clients_p-1:0]                wr_yumi_o,
    output logic                                   r0_v_o,
    output logic [addr_width_lp-1:0]               r0_addr_o,
    input  logic [width_p-1:0]                     r0_data_i,
    output logic                                   r1_v_o,
    output logic [addr_width_lp-1:0]               r1_addr_o,
    input  logic [width_p-1:0]                     r1_data_i,
    output logic                                   w_v_o,
    output logic [addr_width_lp-1:0]               w_addr_o,
    output logic [width_p-1:0]                     w_data_o,
    output logic                                   resp0_v_o,
    output logic [id_width_lp-1:0]                 resp0_id_o,
    output logic [width_p-1:0]                     resp0_data_o,
    output logic                                   resp1_v_o,
    output logic [id_width_lp-1:0]                 resp1_id_o,
    output logic [width_p-1:0]                     resp1_data_o
);
    logic [id_width_lp-1:0]  rd_ptr_q, rd_ptr_d;
    logic [wp_width_lp-1:0]  wr_ptr_q, wr_ptr_d;
    logic [rd_clients_p-1:0] conf, elig, rd0_sel, rd1_sel;
    logic [1:0]              rd_cnt;
    logic [id_width_lp-1:0]  id0, id1;
    logic                    c0, c1;
    logic                    resp0_v_q, resp1_v_q;
    logic [id_width_lp-1:0]  resp0_id_q, resp1_id_q;
    logic [width_p-1:0]      resp0_data_q, resp1_data_q;

    always_comb begin
        wr_yumi_o = '0;
        wr_ptr_d  = wr_ptr_q;
        w_v_o     = 1'b0;
        w_addr_o  = '0;
        w_data_o  = '0;
        for (int k = 0; k < wr_clients_p; k++)
            for (int i = 0; i < wr_clients_p; i++)
                if (reset_n_i && !w_v_o && wr_v_i[i] && i == (int'(wr_ptr_q) + k) % wr_clients_p) begin
                    w_v_o        = 1'b1;
                    wr_yumi_o[i] = 1'b1;
                    w_addr_o     = wr_addr_i[i*addr_width_lp +: addr_width_lp];
                    w_data_o     = wr_data_i[i*width_p +: width_p];
                    wr_ptr_d     = wp_width_lp'((i + 1) % wr_clients_p);
                end
    end

    // Reads that collide with this cycle's write either wait or take the write data
    always_comb begin
        conf = '0;
        elig = '0;
        for (int i = 0; i < rd_clients_p; i++) begin
            conf[i] = w_v_o && rd_addr_i[i*addr_width_lp +: addr_width_lp] == w_addr_o;
`ifdef BSG_MEM_2R1W_RR_SCHED_BYPASS_EN
            elig[i] = reset_n_i && rd_v_i[i];
`else
            elig[i] = reset_n_i && rd_v_i[i] && !conf[i];
`endif
        end
    end

    always_comb begin
        rd0_sel  = '0;
        rd1_sel  = '0;
        rd_cnt   = '0;
        rd_ptr_d = rd_ptr_q;
        for (int k = 0; k < rd_clients_p; k++)
            for (int i = 0; i < rd_clients_p; i++)
                if (elig[i] && rd_cnt != 2'd2 && i == (int'(rd_ptr_q) + k) % rd_clients_p) begin
                    rd0_sel[i] = (rd_cnt == 2'd0);
                    rd1_sel[i] = (rd_cnt == 2'd1);
                    rd_cnt     = rd_cnt + 2'd1;
                    rd_ptr_d   = id_width_lp'((i + 1) % rd_clients_p);
                end
    end

    always_comb begin
        r0_addr_o = '0;
        r1_addr_o = '0;
        id0       = '0;
        id1       = '0;
        c0        = 1'b0;
        c1        = 1'b0;
        for (int i = 0; i < rd_clients_p; i++) begin
            if (rd0_sel[i]) begin
                r0_addr_o = rd_addr_i[i*addr_width_lp +: addr_width_lp];
                id0       = id_width_lp'(i);
                c0        = conf[i];
            end
            if (rd1_sel[i]) begin
                r1_addr_o = rd_addr_i[i*addr_width_lp +: addr_width_lp];
                id1       = id_width_lp'(i);
                c1        = conf[i];
            end
        end
    end

    assign rd_yumi_o = rd0_sel | rd1_sel;
    assign r0_v_o    = |rd0_sel && !c0;
    assign r1_v_o    = |rd1_sel && !c1;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            resp0_v_q    <= 1'b0;
            resp1_v_q    <= 1'b0;
            resp0_id_q   <= '0;
            resp1_id_q   <= '0;
            resp0_data_q <= '0;
            resp1_data_q <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            resp0_v_q <= |rd0_sel;
            resp1_v_q <= |rd1_sel;
            if (|rd0_sel) begin
                resp0_id_q   <= id0;
                resp0_data_q <= c0 ? w_data_o : r0_data_i;
            end
            if (|rd1_sel) begin
                resp1_id_q   <= id1;
                resp1_data_q <= c1 ? w_data_o : r1_data_i;
            end
        end
    end

    assign resp0_v_o    = resp0_v_q;
    assign resp1_v_o    = resp1_v_q;
    assign resp0_id_o   = resp0_id_q;
    assign resp1_id_o   = resp1_id_q;
    assign resp0_data_o = resp0_data_q;
    assign resp1_data_o = resp1_data_q;

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!(w_v_o && ((r0_v_o && r0_addr_o == w_addr_o) || (r1_v_o && r1_addr_o == w_addr_o))));
            assert (!r0_v_o || int'(r0_addr_o) < els_p);
            assert (!r1_v_o || int'(r1_addr_o) < els_p);
            assert (!w_v_o || int'(w_addr_o) < els_p);
        end
    end
`endif
endmodule
